// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for an in-order core.
// The multiplier is a radix-2 shift-add and the divider is a restoring divider.
// Both work on operand magnitudes over 32 iterations, and the sign is fixed up
// at the end. Divide-by-zero and signed overflow skip the iterations.
// Compile-time option: define MULDIV_DIVIDE_EN to build the divide/remainder
// datapath. Without it, funct3[2]=1 completes at once with result 0 and
// raises illegal together with done.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state;
  logic [4:0]          count;
  logic [2:0]          op_q;
  logic                neg_q;      // product / quotient must be negated
  logic [XLEN-1:0]     b_mag;
  logic [2*XLEN-1:0]   acc;        // {high/remainder, low/quotient} working pair
`ifdef MULDIV_DIVIDE_EN
  logic                neg_r;      // remainder must be negated
`endif

  logic                signed_a_in, signed_b_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]     a_mag_in, b_mag_in;
  logic                fast_in;
  logic [XLEN-1:0]     fast_result;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   next_acc;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     final_result;
  logic                ill_op;
`ifdef MULDIV_DIVIDE_EN
  logic [XLEN:0]       rem_shift, diff;
  logic [2*XLEN-1:0]   div_next;
`endif

  // Pipeline hold: the request cycle itself plus every iteration cycle.
  assign stall = ((state == IDLE) && start) || (state == RUN);
  assign busy  = (state != IDLE);

  // Operand conditioning, fast-path detection and one iteration step.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    signed_a_in  = !(funct3 inside {3'b011, 3'b101, 3'b111});
    signed_b_in  = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    a_neg_in     = signed_a_in && src_a[XLEN-1];
    b_neg_in     = signed_b_in && src_b[XLEN-1];
    a_mag_in     = a_neg_in ? ('0 - src_a) : src_a;
    b_mag_in     = b_neg_in ? ('0 - src_b) : src_b;
    fast_in      = 1'b0;
    fast_result  = '0;
`ifdef MULDIV_DIVIDE_EN
    if (funct3[2] && (src_b == '0)) begin
      fast_in     = 1'b1;
      fast_result = funct3[1] ? src_a : '1;
    end else if (funct3[2] && !funct3[0] && (src_a == 32'h8000_0000) &&
                 (src_b == 32'hFFFF_FFFF)) begin
      fast_in     = 1'b1;
      fast_result = funct3[1] ? '0 : 32'h8000_0000;
    end
    ill_op = 1'b0;
`else
    fast_in = funct3[2];
    ill_op  = op_q[2];
`endif

    // Shift-add step: add the multiplicand when the low bit is set, shift right.
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_mag : '0)};
    next_acc = {mul_sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIVIDE_EN
    // Restoring step: shift in the next dividend bit and subtract if it fits.
    rem_shift = acc[2*XLEN-1:XLEN-1];
    diff      = rem_shift - {1'b0, b_mag};
    div_next  = diff[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0],      acc[XLEN-2:0], 1'b1};
    if (op_q[2]) next_acc = div_next;
`endif

    // Sign fix-up and result selection taken from the final iteration.
    prod         = neg_q ? ('0 - next_acc) : next_acc;
    final_result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIVIDE_EN
    if (op_q[2]) begin
      if (op_q[1])
        final_result = neg_r ? ('0 - next_acc[2*XLEN-1:XLEN]) : next_acc[2*XLEN-1:XLEN];
      else
        final_result = neg_q ? ('0 - next_acc[XLEN-1:0]) : next_acc[XLEN-1:0];
    end
`endif
  end

  // Control FSM with registered done/illegal/result and the datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath registers are reset too; they are few and it keeps
    // the whole block in one clean asynchronous-reset process.
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      b_mag   <= '0;
      acc     <= '0;
      result  <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      neg_r   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees the
      // pre-edge values, independent of statement order.
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= funct3;
            neg_q <= a_neg_in ^ b_neg_in;
            b_mag <= b_mag_in;
            acc   <= {{XLEN{1'b0}}, a_mag_in};
            count <= '0;
`ifdef MULDIV_DIVIDE_EN
            neg_r <= a_neg_in;
`endif
            if (fast_in) begin
              result <= fast_result;
              state  <= FIN;
            end else begin
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            count <= '0;
          end else begin
            acc   <= next_acc;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              result <= final_result;
              state  <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          if (!flush) begin
            done    <= 1'b1;
            illegal <= ill_op;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random
// operations. The driver pushes reference-model results into a scoreboard, and
// an independent monitor pops and compares them on every done pulse.
module tb_muldiv_sequencer;

`ifdef MULDIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        stall, busy, done, illegal;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] last_result = '0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain wide arithmetic on sign-extended operands.
  function automatic void ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output logic fast);
    logic               sa, sbit;
    logic signed [32:0] ea, eb;
    logic signed [65:0] p;
`ifdef MULDIV_DIVIDE_EN
    logic signed [32:0] q, m;
`endif
    sa   = f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    sbit = f inside {3'b000, 3'b001, 3'b100, 3'b110};
    ea   = {sa & a[31], a};
    eb   = {sbit & b[31], b};
    ill  = 1'b0;
    fast = 1'b0;
    r    = '0;
    if (!f[2]) begin
      p = ea * eb;
      r = (f == 3'b000) ? p[31:0] : p[63:32];
    end else begin
`ifdef MULDIV_DIVIDE_EN
      if (b == 32'd0) begin
        fast = 1'b1;
        r    = f[1] ? a : 32'hFFFF_FFFF;
      end else if (sa && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        fast = 1'b1;
        r    = f[1] ? 32'd0 : 32'h8000_0000;
      end else begin
        q = ea / eb;
        m = ea % eb;
        r = f[1] ? m[31:0] : q[31:0];
      end
`else
      fast = 1'b1;
      ill  = 1'b1;
`endif
    end
  endfunction

  // Issue one op at a negedge once the unit is idle; returns one cycle later.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic fast;
    int   n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL issue_wait: busy stuck high, got 1, expected 0");
      return;
    end
    funct3 = f;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    ref_op(f, a, b, e.res, e.ill, fast);
    e.due = cyc + 1 + (fast ? 1 : 33);
    sb.push_back(e);
    #1 check("stall_on_start", stall, 1'b1);
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    src_a  = $urandom;
    src_b  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 result=%h, expected no done", result);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("illegal", illegal, e.ill);
          check("done_cycle", cyc, e.due);
          last_result = e.res;
        end
      end else if (illegal) begin
        check("illegal_without_done", illegal, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0]  f;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; src_a = '0; src_b = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MUL 7 x -3, with stall width measured from the request cycle.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    n = 1;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mul_stall_cycles", n, 33);
    drain();
    check("mul_7x-3", result, 32'hFFFF_FFEB);

    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
    check("mulhu_max", result, 32'hFFFF_FFFE);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
    check("mulh_m1", result, 32'd0);

    issue(3'b100, 32'hFFFF_FFF9, 32'd2); drain();
    check("div_-7/2", result, DIV_EN ? 32'hFFFF_FFFD : 32'd0);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2); drain();
    check("rem_-7/2", result, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
    issue(3'b101, 32'd5, 32'd0); drain();
    check("divu_5/0", result, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF); drain();
    check("rem_ovf", result, 32'd0);
    issue(3'b100, 32'd6, 32'd3); drain();
    check("div_6/3", result, DIV_EN ? 32'd2 : 32'd0);

    // Flush has priority over start in IDLE.
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", busy, 1'b0);
    @(negedge clk);

    // Flush at iteration 10: back to IDLE, result held, new op accepted next.
    issue(3'b000, 32'd1234, 32'd5678);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_stall", stall, 1'b0);
    check("flush_result_held", result, last_result);
    issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    check("start_after_flush", busy, 1'b1);
    drain();

    // Asynchronous reset in the middle of RUN.
    issue(3'b001, 32'h0BAD_F00D, 32'h7777_0001);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_stall", stall, 1'b0);
    check("rst_async_result", result, 32'd0);
    sb.delete();
    last_result = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized operations, with stray start pulses while busy.
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'hFFFF_FFFF;
        3: b = 32'h8000_0000;
        default: ;
      endcase
      issue(f, a, b);
      if ($urandom_range(0, 3) == 0 && busy) begin
        start  = 1'b1;
        funct3 = 3'($urandom);
        src_a  = $urandom;
        src_b  = $urandom;
        @(negedge clk);
        start  = 1'b0;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  input  1  EX-stage request; sampled only in IDLE.
REQ-005 The block SHALL have port funct3  input  3  M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports src_a and src_b  input  32  each, rs1 and rs2 operands.
REQ-007 The block SHALL have port flush  input  1  abort the in-flight operation.
REQ-008 The block SHALL have port stall  output  1  hold IF/ID/EX pipeline registers.
REQ-009 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port result  output  32  operation result.
REQ-012 The block SHALL have port illegal  output  1  unsupported op flag.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, FIN: IDLE->RUN on start with normal operands; IDLE->FIN on start with a fast-path case; RUN->FIN after iteration count 31; FIN->IDLE unconditionally.
REQ-014 The block SHALL latch funct3 and operands at acceptance; later changes to funct3 and operands SHALL have no effect.
REQ-015 The block SHALL make stall = (state==IDLE & start) | (state==RUN), combinationally; stall SHALL be low in FIN.
REQ-016 The block SHALL compute multiplies as radix-2 shift-add on operand magnitudes, 32 iterations, 64-bit product, negated when signs differ; MUL returns bits[31:0] and MULH/MULHSU/MULHU return bits[63:32].
REQ-017 The block SHALL treat operand signedness as follows: MULH both signed; MULHSU src_a signed, src_b unsigned; MULHU, DIVU, REMU unsigned; DIV, REM signed.
REQ-018 The block SHALL compute divides by restoring division on magnitudes, 32 iterations; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-019 The block SHALL take the fast path (RUN skipped) for divisor zero: quotient 32'hFFFFFFFF, remainder = src_a.
REQ-020 The block SHALL take the fast path for signed overflow (DIV/REM, a=32'h80000000, b=32'hFFFFFFFF): quotient 32'h80000000, remainder 0.
REQ-021 The block SHALL give normal-op latency as: start accepted at edge N, done high in the cycle after edge N+33; fast-path done high in the cycle after edge N+1.
REQ-022 The block SHALL register result at FIN entry and hold it until the next FIN entry.
REQ-023 The block SHALL ignore start while busy.
REQ-024 The block SHALL respond to flush in RUN or FIN by going to IDLE at the next edge with no done pulse and result unchanged; flush in IDLE SHALL take priority over start.

Reset
REQ-025 The block SHALL on rst, immediately and regardless of clk, set state IDLE, iteration count 0, result 0, done 0, illegal 0; stall and busy SHALL then read 0.
REQ-026 The block SHALL on rst mid-operation discard the operation with no done pulse after release.

Configuration
REQ-027 The block SHALL implement divide/remainder only when macro MULDIV_DIVIDE_EN is defined; with it defined, illegal SHALL be constant 0.
REQ-028 The block SHALL, without MULDIV_DIVIDE_EN, handle funct3[2]=1 by taking the fast path, result 0, and asserting illegal together with done for one cycle; multiplies SHALL be unaffected.

Verification
REQ-029 The bench SHALL check MUL 7 x -3: done after 33 cycles, result 32'hFFFFFFEB, stall high for exactly 33 cycles from start.
REQ-030 The bench SHALL check MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> result 32'hFFFFFFFE; MULH with the same operands -> 0.
REQ-031 The bench SHALL check DIV -7/2 -> 32'hFFFFFFFD and REM -7/2 -> 32'hFFFFFFFF, each with done 33 cycles after start.
REQ-032 The bench SHALL check DIVU 5/0 -> 32'hFFFFFFFF, REM 32'h80000000/-1 -> 0, each with done 2 cycles after start.
REQ-033 The bench SHALL check flush at RUN iteration 10 -> IDLE next cycle, no done, result equal to the prior value; a new start is accepted on the following cycle.
REQ-034 The bench SHALL check rst asserted mid-RUN -> busy/stall low without a clock edge; with MULDIV_DIVIDE_EN undefined, DIV 6/3 -> result 0, illegal=1, done after 2 cycles.
